// File: rtl/bp_me_io_scratch_responder_pkg.sv
// BedRock CCE mem-msg types and widths shared by the I/O scratchpad responder and its decoder.
package bp_me_io_scratch_responder_pkg;

  localparam int unsigned paddr_width_gp     = 40;
  localparam int unsigned cce_block_width_gp = 128;
  localparam int unsigned payload_width_gp   = 16;
  localparam int unsigned word_width_gp      = 64;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1  = 3'd0,
    e_bedrock_msg_size_2  = 3'd1,
    e_bedrock_msg_size_4  = 3'd2,
    e_bedrock_msg_size_8  = 3'd3,
    e_bedrock_msg_size_16 = 3'd4,
    e_bedrock_msg_size_32 = 3'd5,
    e_bedrock_msg_size_64 = 3'd6
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [payload_width_gp-1:0] payload;
    bp_bedrock_msg_size_e        size;
    logic [paddr_width_gp-1:0]   addr;
    bp_bedrock_mem_type_e        msg_type;
  } bp_bedrock_cce_mem_header_s;

  typedef struct packed {
    logic [cce_block_width_gp-1:0] data;
    bp_bedrock_cce_mem_header_s    header;
  } bp_bedrock_cce_mem_msg_s;

  localparam int unsigned cce_mem_msg_width_gp = $bits(bp_bedrock_cce_mem_msg_s);

  // Replicate the low 2^size bytes of word across the whole data block
  function automatic logic [cce_block_width_gp-1:0] replicate_bytes
    (input logic [word_width_gp-1:0] word
    ,input bp_bedrock_msg_size_e     size
    );
    logic [cce_block_width_gp-1:0] r;
    case (size)
      e_bedrock_msg_size_1: r = {(cce_block_width_gp/8){word[7:0]}};
      e_bedrock_msg_size_2: r = {(cce_block_width_gp/16){word[15:0]}};
      e_bedrock_msg_size_4: r = {(cce_block_width_gp/32){word[31:0]}};
      default:              r = {(cce_block_width_gp/64){word}};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bp_me_io_scratch_decode.sv
// Combinational address/type decode of a BedRock command header into word index, byte lanes and a good flag.
module bp_me_io_scratch_decode
  import bp_me_io_scratch_responder_pkg::*;
  #(parameter logic [paddr_width_gp-1:0] base_addr_p = 40'h10_0000
   ,parameter int unsigned els_p = 16
   ,localparam int unsigned lg_els_lp = $clog2(els_p)
   )
  (input  bp_bedrock_cce_mem_header_s header_i
  ,output logic [lg_els_lp-1:0]       word_idx_c
  ,output logic [7:0]                 byte_mask_c
  ,output logic                       good_c
  );

  localparam logic [paddr_width_gp-1:0] span_lp = paddr_width_gp'(8 * els_p);

  logic [paddr_width_gp-1:0] off;
  logic [7:0] size_mask;
  logic [2:0] align_mask;
  logic type_ok, range_ok, size_ok, align_ok;
  logic unused_payload;

  assign unused_payload = ^header_i.payload;

  always_comb begin
    size_mask  = 8'h00;
    align_mask = 3'b000;
    size_ok    = 1'b1;
    case (header_i.size)
      e_bedrock_msg_size_1: begin size_mask = 8'h01; align_mask = 3'b000; end
      e_bedrock_msg_size_2: begin size_mask = 8'h03; align_mask = 3'b001; end
      e_bedrock_msg_size_4: begin size_mask = 8'h0F; align_mask = 3'b011; end
      e_bedrock_msg_size_8: begin size_mask = 8'hFF; align_mask = 3'b111; end
      default:              size_ok = 1'b0;
    endcase

    off      = header_i.addr - base_addr_p;
    type_ok  = (header_i.msg_type == e_bedrock_mem_uc_rd)
            || (header_i.msg_type == e_bedrock_mem_uc_wr)
            || (header_i.msg_type == e_bedrock_mem_wr);
    // addr >= base rules out wrap of off, so the span compare alone bounds the top
    range_ok = (header_i.addr >= base_addr_p) && (off < span_lp);
    align_ok = (header_i.addr[2:0] & align_mask) == 3'b000;
    good_c   = type_ok & range_ok & size_ok & align_ok;

    word_idx_c  = off[3 +: lg_els_lp];
    byte_mask_c = good_c ? (size_mask << header_i.addr[2:0]) : 8'h00;
  end

endmodule

// File: rtl/bp_me_io_scratch_responder.sv
// BedRock uncached I/O responder: serves rd/wr commands from a flop scratchpad, one response per command.
module bp_me_io_scratch_responder
  import bp_me_io_scratch_responder_pkg::*;
  #(parameter logic [paddr_width_gp-1:0] base_addr_p = 40'h10_0000
   ,parameter int unsigned els_p = 16
   ,parameter int unsigned latency_p = 1
   ,parameter int unsigned err_cnt_width_p = 16
   ,localparam int unsigned lg_els_lp = $clog2(els_p)
   )
  (input  logic                         clk_i
  ,input  logic                         reset_n_i
  ,input  bp_bedrock_cce_mem_msg_s      mem_cmd_i
  ,input  logic                         mem_cmd_v_i
  ,output logic                         mem_cmd_ready_o
  ,output bp_bedrock_cce_mem_msg_s      mem_resp_o
  ,output logic                         mem_resp_v_o
  ,input  logic                         mem_resp_yumi_i
  ,output logic                         err_o
  ,output logic [err_cnt_width_p-1:0]   err_cnt_o
  );

  typedef enum logic [1:0] {e_idle, e_wait, e_resp} state_e;

  state_e                      state_r;
  bp_bedrock_cce_mem_msg_s     cmd_r;
  bp_bedrock_cce_mem_msg_s     access_cmd;
  logic [3:0]                  wait_cnt_r;
  logic [word_width_gp-1:0]    mem_r [els_p];

  logic [lg_els_lp-1:0]        word_idx;
  logic [7:0]                  byte_mask;
  logic                        good;
  logic                        cmd_accept, is_write, enter_resp, do_write;
  logic [5:0]                  shamt;
  logic [word_width_gp-1:0]    bit_mask, wr_word, rd_word;
  logic [cce_block_width_gp-1:0] resp_data;
  logic                        unused_data_hi;

  // With zero latency the access happens on the accept edge, before cmd_r holds the command
  assign access_cmd     = (state_r == e_idle) ? mem_cmd_i : cmd_r;
  assign unused_data_hi = ^access_cmd.data[cce_block_width_gp-1:word_width_gp];

  bp_me_io_scratch_decode
   #(.base_addr_p(base_addr_p)
    ,.els_p(els_p)
    )
   decode
    (.header_i(access_cmd.header)
    ,.word_idx_c(word_idx)
    ,.byte_mask_c(byte_mask)
    ,.good_c(good)
    );

  always_comb begin
    cmd_accept = mem_cmd_v_i & mem_cmd_ready_o;
    enter_resp = ((state_r == e_wait) && (wait_cnt_r == 4'd0))
              || ((state_r == e_idle) && cmd_accept && (latency_p == 0));
    is_write   = (access_cmd.header.msg_type == e_bedrock_mem_uc_wr)
              || (access_cmd.header.msg_type == e_bedrock_mem_wr);
    do_write   = enter_resp & good & is_write;
    shamt      = {access_cmd.header.addr[2:0], 3'b000};

    bit_mask = '0;
    for (int b = 0; b < 8; b++) bit_mask[8*b +: 8] = {8{byte_mask[b]}};

    wr_word   = (mem_r[word_idx] & ~bit_mask)
              | ((access_cmd.data[word_width_gp-1:0] << shamt) & bit_mask);
    rd_word   = do_write ? wr_word : mem_r[word_idx];
    resp_data = (good && !is_write)
              ? replicate_bytes(rd_word >> shamt, access_cmd.header.size)
              : '0;
  end

  // Control FSM with registered handshake, response and error outputs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r         <= e_idle;
      cmd_r           <= '0;
      wait_cnt_r      <= 4'd0;
      mem_cmd_ready_o <= 1'b0;
      mem_resp_v_o    <= 1'b0;
      mem_resp_o      <= '0;
      err_o           <= 1'b0;
      err_cnt_o       <= '0;
    end else begin
      case (state_r)
        e_idle: begin
          mem_cmd_ready_o <= 1'b1;
          if (cmd_accept) begin
            cmd_r           <= mem_cmd_i;
            mem_cmd_ready_o <= 1'b0;
            if (latency_p == 0) begin
              state_r <= e_resp;
            end else begin
              state_r    <= e_wait;
              wait_cnt_r <= 4'(latency_p - 1);
            end
          end
        end
        e_wait: begin
          if (wait_cnt_r != 4'd0) wait_cnt_r <= wait_cnt_r - 4'd1;
          else                    state_r    <= e_resp;
        end
        e_resp: begin
          if (mem_resp_yumi_i) begin
            state_r         <= e_idle;
            mem_resp_v_o    <= 1'b0;
            mem_cmd_ready_o <= 1'b1;
          end
        end
        default: state_r <= e_idle;
      endcase

      if (enter_resp) begin
        mem_resp_v_o <= 1'b1;
        mem_resp_o   <= '{data: resp_data, header: access_cmd.header};
        if (!good) begin
          err_o <= 1'b1;
          if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + err_cnt_width_p'(1);
        end
      end
    end
  end

  // Scratchpad storage; writes commit on the edge that enters RESP
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < int'(els_p); i++) mem_r[i] <= '0;
    end else if (do_write) begin
      mem_r[word_idx] <= wr_word;
    end
  end

endmodule

// File: tb/tb_bp_me_io_scratch_responder.sv
// Scoreboard bench for bp_me_io_scratch_responder: byte-array reference model, randomized traffic plus directed cases.
module tb_bp_me_io_scratch_responder;
  import bp_me_io_scratch_responder_pkg::*;

  localparam logic [39:0] BASE  = 40'h10_0000;
  localparam int unsigned ELS   = 16;
  localparam int unsigned LAT   = 3;
  localparam int unsigned ERRW  = 4;
  localparam int unsigned NRAND = 300;

  typedef struct {
    bp_bedrock_cce_mem_msg_s msg;
    int acc;
    int err;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  bp_bedrock_cce_mem_msg_s mem_cmd, mem_resp;
  logic mem_cmd_v, ready, resp_v, yumi, err;
  logic [ERRW-1:0] err_cnt;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] mmem [8*ELS];
  int m_err, m_cnt;
  bp_bedrock_cce_mem_msg_s last_resp;
  int yumi_cyc = 0;
  int hold_req = 0;
  int hold_ack = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bp_me_io_scratch_responder
   #(.base_addr_p(BASE), .els_p(ELS), .latency_p(LAT), .err_cnt_width_p(ERRW))
   dut
    (.clk_i(clk)
    ,.reset_n_i(reset_n)
    ,.mem_cmd_i(mem_cmd)
    ,.mem_cmd_v_i(mem_cmd_v)
    ,.mem_cmd_ready_o(ready)
    ,.mem_resp_o(mem_resp)
    ,.mem_resp_v_o(resp_v)
    ,.mem_resp_yumi_i(yumi)
    ,.err_o(err)
    ,.err_cnt_o(err_cnt)
    );

  function automatic void chk(string name, logic [255:0] got, logic [255:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < int'(8*ELS); i++) mmem[i] = 8'h00;
    m_err = 0;
    m_cnt = 0;
  endfunction

  // Reference: byte-addressed memory, legality from the protocol rules
  function automatic bp_bedrock_cce_mem_msg_s model(input bp_bedrock_cce_mem_msg_s c);
    bp_bedrock_cce_mem_msg_s r;
    int n;
    longint off;
    bit good, is_rd;
    n     = 1 << int'(c.header.size);
    off   = longint'(c.header.addr) - longint'(BASE);
    is_rd = (c.header.msg_type == e_bedrock_mem_uc_rd);
    good  = (is_rd || c.header.msg_type == e_bedrock_mem_uc_wr || c.header.msg_type == e_bedrock_mem_wr)
         && (off >= 0) && (off < longint'(8*ELS)) && (n <= 8) && ((off % n) == 0);
    r.header = c.header;
    r.data   = '0;
    if (!good) begin
      m_err = 1;
      if (m_cnt < (1 << ERRW) - 1) m_cnt++;
    end else if (is_rd) begin
      for (int k = 0; k < 16; k++) r.data[8*k +: 8] = mmem[int'(off) + (k % n)];
    end else begin
      for (int i = 0; i < n; i++) mmem[int'(off) + i] = c.data[8*i +: 8];
    end
    return r;
  endfunction

  function automatic bp_bedrock_cce_mem_msg_s mk(bp_bedrock_mem_type_e t, logic [39:0] a,
                                                 int unsigned sz, logic [127:0] d);
    bp_bedrock_cce_mem_msg_s m;
    m.header.msg_type = t;
    m.header.addr     = a;
    m.header.size     = bp_bedrock_msg_size_e'(3'(sz));
    m.header.payload  = 16'($urandom);
    m.data            = d;
    return m;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input bp_bedrock_cce_mem_msg_s c, output int acc);
    exp_t e;
    int n = 0;
    @(negedge clk);
    mem_cmd   = c;
    mem_cmd_v = 1'b1;
    while (!ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      chk("send_timeout", 256'(ready), 256'(1));
    end else begin
      e.msg = model(c);
      e.acc = cyc;
      e.err = m_err;
      e.cnt = m_cnt;
      exp_q.push_back(e);
    end
    acc = cyc;
    @(posedge clk);
    #1 mem_cmd_v = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || resp_v) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("drain_timeout", 256'(exp_q.size()), 256'(0));
    @(negedge clk);
  endtask

  // Monitor: checks timing/stability and pops the scoreboard when it consumes a response
  initial begin
    bit seen = 1'b0;
    int hold_left = 0;
    bp_bedrock_cce_mem_msg_s held;
    exp_t e;
    yumi = 1'b0;
    forever begin
      @(negedge clk);
      yumi = 1'b0;
      if (!reset_n) begin
        exp_q.delete();
        seen = 1'b0;
        hold_left = 0;
      end else if (resp_v) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 256'(resp_v), 256'(0));
        end else begin
          if (!seen) begin
            seen = 1'b1;
            held = mem_resp;
            chk("resp_latency", 256'(cyc), 256'(exp_q[0].acc + int'(LAT) + 1));
            if (hold_req != hold_ack) begin
              hold_ack  = hold_req;
              hold_left = 20;
            end
          end else begin
            chk("resp_stable", 256'(mem_resp), 256'(held));
            chk("ready_low_in_resp", 256'(ready), 256'(0));
          end
          if (hold_left > 0) begin
            hold_left--;
          end else if ($urandom_range(0, 1) == 1) begin
            e = exp_q.pop_front();
            chk("resp_msg", 256'(mem_resp), 256'(e.msg));
            chk("err_o", 256'(err), 256'(e.err));
            chk("err_cnt_o", 256'(err_cnt), 256'(e.cnt));
            last_resp = mem_resp;
            yumi      = 1'b1;
            yumi_cyc  = cyc;
            seen      = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, choice, n, boff;
    int unsigned sz;
    bp_bedrock_mem_type_e t;
    logic [39:0] a;
    mem_cmd   = '0;
    mem_cmd_v = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_ready", 256'(ready), 256'(0));
    chk("rst_resp_v", 256'(resp_v), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    chk("rst_err_cnt", 256'(err_cnt), 256'(0));
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 256'(ready), 256'(1));

    // 8B write then read
    send(mk(e_bedrock_mem_uc_wr, BASE, 3, 128'hDEAD_BEEF_CAFE_F00D), acc);
    send(mk(e_bedrock_mem_uc_rd, BASE, 3, '0), acc);
    drain();
    chk("t1_rd8", 256'(last_resp.data[63:0]), 256'(64'hDEAD_BEEF_CAFE_F00D));
    chk("t1_err", 256'(err), 256'(0));

    // byte write merges into the word; 2B read replicates
    send(mk(e_bedrock_mem_uc_wr, BASE + 40'd3, 0, 128'hA5), acc);
    send(mk(e_bedrock_mem_uc_rd, BASE, 3, '0), acc);
    drain();
    chk("t2_rd8", 256'(last_resp.data[63:0]), 256'(64'hDEAD_BEEF_A5FE_F00D));
    send(mk(e_bedrock_mem_uc_rd, BASE + 40'd2, 1, '0), acc);
    drain();
    chk("t2_rd2", 256'(last_resp.data), 256'({8{16'hA5FE}}));

    // out-of-range and misaligned writes are dropped and counted
    send(mk(e_bedrock_mem_uc_wr, BASE + 40'(8*ELS), 3, rnd128()), acc);
    send(mk(e_bedrock_mem_uc_wr, BASE + 40'd2, 2, rnd128()), acc);
    drain();
    chk("t3_err", 256'(err), 256'(1));
    chk("t3_err_cnt", 256'(err_cnt), 256'(2));
    send(mk(e_bedrock_mem_uc_rd, BASE, 3, '0), acc);
    drain();
    chk("t3_rd8", 256'(last_resp.data[63:0]), 256'(64'hDEAD_BEEF_A5FE_F00D));

    // unsupported msg_type
    send(mk(e_bedrock_mem_amo, BASE, 3, rnd128()), acc);
    drain();
    chk("t6_amo_data", 256'(last_resp.data), 256'(0));
    chk("t6_err_cnt", 256'(err_cnt), 256'(3));
    send(mk(e_bedrock_mem_uc_rd, BASE, 3, '0), acc);
    drain();
    chk("t6_rd8", 256'(last_resp.data[63:0]), 256'(64'hDEAD_BEEF_A5FE_F00D));

    // consumer stalls; a waiting command is accepted one cycle after yumi
    hold_req++;
    send(mk(e_bedrock_mem_uc_wr, BASE + 40'd16, 3, rnd128()), acc);
    send(mk(e_bedrock_mem_uc_rd, BASE + 40'd16, 3, '0), acc2);
    chk("t4_accept_after_yumi", 256'(acc2), 256'(yumi_cyc + 1));
    drain();

    // reset during WAIT discards the command
    send(mk(e_bedrock_mem_uc_wr, BASE, 3, 128'h1122_3344_5566_7788), acc);
    #1 reset_n = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      chk("t5_rst_ready", 256'(ready), 256'(0));
      chk("t5_rst_resp_v", 256'(resp_v), 256'(0));
      chk("t5_rst_err_cnt", 256'(err_cnt), 256'(0));
    end
    reset_n = 1'b1;
    @(negedge clk);
    chk("t5_ready", 256'(ready), 256'(1));
    repeat (6) begin
      @(negedge clk);
      chk("t5_no_resp", 256'(resp_v), 256'(0));
    end
    send(mk(e_bedrock_mem_uc_rd, BASE, 3, '0), acc);
    drain();
    chk("t5_rd_zero", 256'(last_resp.data), 256'(0));
    chk("t5_err", 256'(err), 256'(0));

    // randomized traffic
    for (int i = 0; i < int'(NRAND); i++) begin
      choice = int'($urandom_range(0, 9));
      if (choice <= 4)      t = e_bedrock_mem_uc_rd;
      else if (choice <= 7) t = e_bedrock_mem_uc_wr;
      else if (choice == 8) t = e_bedrock_mem_wr;
      else begin
        case ($urandom_range(0, 2))
          0:       t = e_bedrock_mem_rd;
          1:       t = e_bedrock_mem_pre;
          default: t = e_bedrock_mem_amo;
        endcase
      end
      sz = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      n  = (sz <= 3) ? (1 << sz) : 8;
      boff = int'($urandom_range(0, 7));
      if ($urandom_range(0, 5) != 0) boff = boff & ~(n - 1);
      choice = int'($urandom_range(0, 9));
      if (choice == 0)      a = BASE - 40'(8 * $urandom_range(1, 4));
      else if (choice == 1) a = BASE + 40'(8*ELS) + 40'(8 * $urandom_range(0, 3));
      else                  a = BASE + 40'(8 * $urandom_range(0, ELS-1)) + 40'(boff);
      send(mk(t, a, sz, rnd128()), acc);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();
    chk("final_err_cnt", 256'(err_cnt), 256'(m_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
